// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: unit select and function codes, MIPS opcodes/functs, and the held entry record.
// Referenced by alu_issue_decode and alu_issue_stage.
package alu_pkg;

    localparam int DW = 32;

    localparam logic [1:0] SEL_ARITH = 2'b00;
    localparam logic [1:0] SEL_LOGIC = 2'b01;
    localparam logic [1:0] SEL_SHIFT = 2'b10;
    localparam logic [1:0] SEL_CMP   = 2'b11;

    localparam logic [3:0] FT_AND   = 4'b1000;
    localparam logic [3:0] FT_OR    = 4'b1110;
    localparam logic [3:0] FT_XOR   = 4'b0110;
    localparam logic [3:0] FT_NOR   = 4'b0001;
    localparam logic [3:0] FT_PASSA = 4'b1010;
    localparam logic [3:0] FT_ADD   = 4'b0010;
    localparam logic [3:0] FT_ADDU  = 4'b0000;
    localparam logic [3:0] FT_SUB   = 4'b0011;
    localparam logic [3:0] FT_SUBU  = 4'b0001;
    localparam logic [3:0] FT_SLT   = 4'b0000;
    localparam logic [3:0] FT_SLTU  = 4'b0001;
    localparam logic [3:0] FT_SLL   = 4'b0000;
    localparam logic [3:0] FT_SRL   = 4'b0001;
    localparam logic [3:0] FT_SRA   = 4'b0011;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [1:0]    sel;
        logic [3:0]    ft;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          illegal;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS opcode/funct decode into ALU unit select, function code and operands A/B.
// Zero latency, no state; unknown encodings become an illegal pass-A of zero.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [5:0]    i_opcode,
    input  logic [5:0]    i_funct,
    input  logic [4:0]    i_shamt,
    input  logic [15:0]   i_imm16,
    input  logic [DW-1:0] i_rs,
    input  logic [DW-1:0] i_rt,
    output logic [1:0]    o_sel,
    output logic [3:0]    o_ft,
    output logic [DW-1:0] o_a,
    output logic [DW-1:0] o_b,
    output logic          o_illegal
);

    logic [DW-1:0] w_sext;
    logic [DW-1:0] w_zext;

    assign w_sext = {{16{i_imm16[15]}}, i_imm16};
    assign w_zext = {16'h0000, i_imm16};

    always_comb begin
        o_sel     = SEL_LOGIC;
        o_ft      = FT_PASSA;
        o_a       = '0;
        o_b       = '0;
        o_illegal = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                o_a       = i_rs;
                o_b       = i_rt;
                o_illegal = 1'b0;
                case (i_funct)
                    FN_AND:  o_ft = FT_AND;
                    FN_OR:   o_ft = FT_OR;
                    FN_XOR:  o_ft = FT_XOR;
                    FN_NOR:  o_ft = FT_NOR;
                    FN_ADD:  begin o_sel = SEL_ARITH; o_ft = FT_ADD;  end
                    FN_ADDU: begin o_sel = SEL_ARITH; o_ft = FT_ADDU; end
                    FN_SUB:  begin o_sel = SEL_ARITH; o_ft = FT_SUB;  end
                    FN_SUBU: begin o_sel = SEL_ARITH; o_ft = FT_SUBU; end
                    FN_SLT:  begin o_sel = SEL_CMP;   o_ft = FT_SLT;  end
                    FN_SLTU: begin o_sel = SEL_CMP;   o_ft = FT_SLTU; end
                    FN_SLL:  begin o_sel = SEL_SHIFT; o_ft = FT_SLL; o_a = {27'b0, i_shamt}; end
                    FN_SRL:  begin o_sel = SEL_SHIFT; o_ft = FT_SRL; o_a = {27'b0, i_shamt}; end
                    FN_SRA:  begin o_sel = SEL_SHIFT; o_ft = FT_SRA; o_a = {27'b0, i_shamt}; end
                    default: begin o_a = '0; o_b = '0; o_illegal = 1'b1; end
                endcase
            end
            OP_ANDI:  begin o_illegal = 1'b0; o_ft = FT_AND; o_a = i_rs; o_b = w_zext; end
            OP_ORI:   begin o_illegal = 1'b0; o_ft = FT_OR;  o_a = i_rs; o_b = w_zext; end
            OP_XORI:  begin o_illegal = 1'b0; o_ft = FT_XOR; o_a = i_rs; o_b = w_zext; end
            OP_ADDI:  begin o_illegal = 1'b0; o_sel = SEL_ARITH; o_ft = FT_ADD;  o_a = i_rs; o_b = w_sext; end
            OP_ADDIU: begin o_illegal = 1'b0; o_sel = SEL_ARITH; o_ft = FT_ADDU; o_a = i_rs; o_b = w_sext; end
            OP_SLTI:  begin o_illegal = 1'b0; o_sel = SEL_CMP;   o_ft = FT_SLT;  o_a = i_rs; o_b = w_sext; end
            OP_SLTIU: begin o_illegal = 1'b0; o_sel = SEL_CMP;   o_ft = FT_SLTU; o_a = i_rs; o_b = w_sext; end
            // LUI rides the logic unit as pass-A with the shifted immediate in A
            OP_LUI:   begin o_illegal = 1'b0; o_a = {i_imm16, 16'h0000}; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes into A/B/sel/ft and holds it in a main+skid valid/ready stage (ALU_ISSUE_FORWARD_EN adds operand forwarding).
// One cycle latency; in_ready is registered and drops only when the skid entry is occupied.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DW_P = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [4:0]      shamt,
    input  logic [15:0]     imm16,
    input  logic [DW_P-1:0] rs_data,
    input  logic [DW_P-1:0] rt_data,
`ifdef ALU_ISSUE_FORWARD_EN
    input  logic [4:0]      rs_addr,
    input  logic [4:0]      rt_addr,
    input  logic            fwd_valid,
    input  logic [4:0]      fwd_addr,
    input  logic [DW_P-1:0] fwd_data,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_P-1:0] alu_a,
    output logic [DW_P-1:0] alu_b,
    output logic [1:0]      alu_sel,
    output logic [3:0]      alu_ft,
    output logic            alu_illegal
);

    logic [DW-1:0] w_rs;
    logic [DW-1:0] w_rt;
    entry_t        w_entry;
    entry_t        r_main;
    entry_t        r_skid;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_in_ready;
    logic          w_in_xfer;
    logic          w_out_xfer;
    logic          w_load_main;
    logic          w_load_skid;
    logic          w_main_from_skid;

`ifdef ALU_ISSUE_FORWARD_EN
    // Register zero is never forwarded
    assign w_rs = (fwd_valid && (fwd_addr != 5'd0) && (fwd_addr == rs_addr)) ? fwd_data : rs_data;
    assign w_rt = (fwd_valid && (fwd_addr != 5'd0) && (fwd_addr == rt_addr)) ? fwd_data : rt_data;
`else
    assign w_rs = rs_data;
    assign w_rt = rt_data;
`endif

    alu_issue_decode u_decode (
        .i_opcode  (opcode),
        .i_funct   (funct),
        .i_shamt   (shamt),
        .i_imm16   (imm16),
        .i_rs      (w_rs),
        .i_rt      (w_rt),
        .o_sel     (w_entry.sel),
        .o_ft      (w_entry.ft),
        .o_a       (w_entry.a),
        .o_b       (w_entry.b),
        .o_illegal (w_entry.illegal)
    );

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = (r_state != ST_EMPTY) && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = ST_FULL;
                    w_load_main = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_in_xfer) begin
                    w_state_nxt = ST_SKID;
                    w_load_skid = 1'b1;
                end
            end
            ST_SKID: begin
                if (w_out_xfer) begin
                    w_state_nxt      = ST_FULL;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main      = 1'b0;
            w_load_skid      = 1'b0;
            w_main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_SKID);
            if (w_load_main) begin
                r_main <= w_entry;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_entry;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != ST_EMPTY);
    assign alu_a       = r_main.a;
    assign alu_b       = r_main.b;
    assign alu_sel     = r_main.sel;
    assign alu_ft      = r_main.ft;
    assign alu_illegal = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, skid backpressure, flush and reset.
// Forwarding vectors run only when ALU_ISSUE_FORWARD_EN is defined.
module tb_alu_issue_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
`ifdef ALU_ISSUE_FORWARD_EN
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [1:0]  alu_sel;
    logic [3:0]  alu_ft;
    logic        alu_illegal;

    int checks   = 0;
    int failures = 0;

    alu_issue_stage dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct       (funct),
        .shamt       (shamt),
        .imm16       (imm16),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
`ifdef ALU_ISSUE_FORWARD_EN
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_ft      (alu_ft),
        .alu_illegal (alu_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
        opcode   = op;
        funct    = fn;
        shamt    = sh;
        imm16    = imm;
        rs_data  = rs;
        rt_data  = rt;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
        drive(op, fn, sh, imm, rs, rt);
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] sel, input logic [3:0] ft,
                              input logic [31:0] a, input logic [31:0] b, input logic ill);
        chk({tag, "_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_sel"}, 64'(alu_sel), 64'(sel));
        chk({tag, "_ft"},  64'(alu_ft), 64'(ft));
        chk({tag, "_a"},   64'(alu_a), 64'(a));
        chk({tag, "_b"},   64'(alu_b), 64'(b));
        chk({tag, "_ill"}, 64'(alu_illegal), 64'(ill));
    endtask

    task automatic expect_zero(input string tag);
        chk({tag, "_vld"}, 64'(out_valid), 64'd0);
        chk({tag, "_a"},   64'(alu_a), 64'd0);
        chk({tag, "_b"},   64'(alu_b), 64'd0);
        chk({tag, "_sel"}, 64'(alu_sel), 64'd0);
        chk({tag, "_ft"},  64'(alu_ft), 64'd0);
        chk({tag, "_ill"}, 64'(alu_illegal), 64'd0);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; funct = '0; shamt = '0; imm16 = '0; rs_data = '0; rt_data = '0;
`ifdef ALU_ISSUE_FORWARD_EN
        rs_addr = '0; rt_addr = '0; fwd_valid = 1'b0; fwd_addr = '0; fwd_data = '0;
`endif
        step(); step();
        expect_zero("reset");
        reset = 1'b0;
        step();
        chk("post_reset_rdy", 64'(in_ready), 64'd1);
        chk("post_reset_vld", 64'(out_valid), 64'd0);

        // Decode vectors, consumed immediately
        out_ready = 1'b1;
        send(6'h0D, 6'h00, 5'd0, 16'h0F0F, 32'h0000_F0F0, 32'h0);
        expect_out("ori", 2'b01, 4'b1110, 32'h0000_F0F0, 32'h0000_0F0F, 1'b0);
        step();
        chk("ori_drained", 64'(out_valid), 64'd0);
        send(6'h0F, 6'h00, 5'd0, 16'h1234, 32'hFFFF_FFFF, 32'h5);
        expect_out("lui", 2'b01, 4'b1010, 32'h1234_0000, 32'h0, 1'b0);
        send(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'h0000_0005, 32'h0);
        expect_out("addi", 2'b00, 4'b0010, 32'h5, 32'hFFFF_FFFF, 1'b0);
        send(6'h00, 6'h22, 5'd0, 16'h0, 32'h10, 32'h3);
        expect_out("sub", 2'b00, 4'b0011, 32'h10, 32'h3, 1'b0);
        send(6'h00, 6'h03, 5'd7, 16'h0, 32'h1111_1111, 32'h8000_0000);
        expect_out("sra", 2'b10, 4'b0011, 32'h7, 32'h8000_0000, 1'b0);
        send(6'h00, 6'h27, 5'd0, 16'h0, 32'hA5A5_0000, 32'h0000_5A5A);
        expect_out("nor", 2'b01, 4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
        send(6'h0B, 6'h00, 5'd0, 16'h8000, 32'h42, 32'h0);
        expect_out("sltiu", 2'b11, 4'b0001, 32'h42, 32'hFFFF_8000, 1'b0);
        send(6'h0C, 6'h00, 5'd0, 16'h8000, 32'hFFFF_FFFF, 32'h0);
        expect_out("andi", 2'b01, 4'b1000, 32'hFFFF_FFFF, 32'h0000_8000, 1'b0);
        send(6'h00, 6'h2A, 5'd0, 16'h0, 32'h7, 32'h9);
        expect_out("slt", 2'b11, 4'b0000, 32'h7, 32'h9, 1'b0);
        send(6'h3F, 6'h20, 5'd3, 16'h1234, 32'h1234_5678, 32'h9ABC_DEF0);
        expect_out("illop", 2'b01, 4'b1010, 32'h0, 32'h0, 1'b1);
        send(6'h00, 6'h3F, 5'd3, 16'h0, 32'h1234_5678, 32'h9ABC_DEF0);
        expect_out("illfn", 2'b01, 4'b1010, 32'h0, 32'h0, 1'b1);
        step();
        chk("idle_vld", 64'(out_valid), 64'd0);

        // Backpressure: three offers with EX stalled, only two accepted
        out_ready = 1'b0;
        drive(6'h09, 6'h00, 5'd0, 16'h0, 32'h111, 32'h0);
        step();
        chk("bp1_rdy", 64'(in_ready), 64'd1);
        chk("bp1_a", 64'(alu_a), 64'h111);
        drive(6'h09, 6'h00, 5'd0, 16'h0, 32'h222, 32'h0);
        step();
        chk("bp2_rdy", 64'(in_ready), 64'd0);
        chk("bp2_a", 64'(alu_a), 64'h111);
        drive(6'h09, 6'h00, 5'd0, 16'h0, 32'h333, 32'h0);
        step();
        chk("bp3_rdy", 64'(in_ready), 64'd0);
        chk("bp3_vld", 64'(out_valid), 64'd1);
        chk("bp3_a_stable", 64'(alu_a), 64'h111);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("drain1_vld", 64'(out_valid), 64'd1);
        chk("drain1_a", 64'(alu_a), 64'h222);
        chk("drain1_rdy", 64'(in_ready), 64'd1);
        step();
        chk("drain2_vld", 64'(out_valid), 64'd0);

        // Flush from SKID with a same-cycle offer that must be dropped
        out_ready = 1'b0;
        send(6'h09, 6'h00, 5'd0, 16'h0, 32'h444, 32'h0);
        send(6'h09, 6'h00, 5'd0, 16'h0, 32'h555, 32'h0);
        chk("pre_flush_rdy", 64'(in_ready), 64'd0);
        drive(6'h09, 6'h00, 5'd0, 16'h0, 32'h666, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_vld", 64'(out_valid), 64'd0);
        chk("flush_rdy", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        chk("flush_hold1", 64'(out_valid), 64'd0);
        step();
        chk("flush_hold2", 64'(out_valid), 64'd0);
        send(6'h09, 6'h00, 5'd0, 16'h0, 32'h777, 32'h0);
        chk("post_flush_a", 64'(alu_a), 64'h777);

        // Reset with both entries held
        out_ready = 1'b0;
        send(6'h0D, 6'h00, 5'd0, 16'hAAAA, 32'h888, 32'h0);
        chk("pre_rst_rdy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        step();
        expect_zero("midrst");
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        chk("midrst_rdy", 64'(in_ready), 64'd1);
        chk("midrst_vld", 64'(out_valid), 64'd0);

`ifdef ALU_ISSUE_FORWARD_EN
        rs_addr = 5'd5; rt_addr = 5'd6; fwd_valid = 1'b1; fwd_addr = 5'd5; fwd_data = 32'hDEAD_BEEF;
        send(6'h00, 6'h21, 5'd0, 16'h0, 32'h1, 32'h2);
        expect_out("fwd_rs", 2'b00, 4'b0000, 32'hDEAD_BEEF, 32'h2, 1'b0);
        rs_addr = 5'd0; rt_addr = 5'd0; fwd_addr = 5'd0;
        send(6'h00, 6'h21, 5'd0, 16'h0, 32'h1, 32'h2);
        expect_out("fwd_zero", 2'b00, 4'b0000, 32'h1, 32'h2, 1'b0);
        fwd_valid = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
